// File: rtl/microseq.sv
// Am2910-style microprogram sequencer: selects the next microinstruction address
// from the micro-PC, a LIFO subroutine/loop stack, a down-counter or the branch input.
module microseq #(
  parameter int AW    = 12,
  parameter int DEPTH = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    inst,
  input  logic          cc_n,
  input  logic          ccen_n,
  input  logic [AW-1:0] d,
  input  logic          rld_n,
  input  logic          ci,
  output logic [AW-1:0] y,
  output logic          full_n,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);
  localparam logic [AW-1:0]  R_ONE  = AW'(1);

  typedef enum logic [3:0] {
    JZ   = 4'd0,  CJS  = 4'd1,  JMAP = 4'd2,  CJP  = 4'd3,
    PUSH = 4'd4,  JSRP = 4'd5,  CJV  = 4'd6,  JRP  = 4'd7,
    RFCT = 4'd8,  RPCT = 4'd9,  CRTN = 4'd10, CJPP = 4'd11,
    LDCT = 4'd12, LOOP = 4'd13, CONT = 4'd14, TWB  = 4'd15
  } inst_e;

  logic [AW-1:0]  upc;
  logic [AW-1:0]  cnt;
  logic [SPW-1:0] sp;
  logic [AW-1:0]  stack [DEPTH];

  logic           pass;
  logic           cnt_zero;
  logic [AW-1:0]  f;
  logic           do_push;
  logic           do_pop;
  logic           do_clr;
  logic           do_ld;
  logic           do_dec;

  assign pass     = ccen_n | ~cc_n;
  assign cnt_zero = (cnt == '0);
  // An empty stack reads as address zero.
  assign f        = (sp == '0) ? '0 : stack[sp - SP_ONE];
  assign full_n   = (sp != SP_MAX);

  assign map_n  = (inst != JMAP);
  assign vect_n = (inst != CJV);
  assign pl_n   = ~((inst != JMAP) && (inst != CJV));

  always_comb begin
    y       = upc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_clr  = 1'b0;
    do_ld   = 1'b0;
    do_dec  = 1'b0;
    case (inst)
      JZ: begin
        y      = '0;
        do_clr = 1'b1;
      end
      CJS: begin
        if (pass) begin
          y       = d;
          do_push = 1'b1;
        end
      end
      JMAP: y = d;
      CJP:  if (pass) y = d;
      PUSH: begin
        do_push = 1'b1;
        do_ld   = pass;
      end
      JSRP: begin
        do_push = 1'b1;
        y       = pass ? d : cnt;
      end
      CJV:  if (pass) y = d;
      JRP:  y = pass ? d : cnt;
      RFCT: begin
        if (!cnt_zero) begin
          y      = f;
          do_dec = 1'b1;
        end else begin
          do_pop = 1'b1;
        end
      end
      RPCT: begin
        if (!cnt_zero) begin
          y      = d;
          do_dec = 1'b1;
        end
      end
      CRTN: begin
        if (pass) begin
          y      = f;
          do_pop = 1'b1;
        end
      end
      CJPP: begin
        if (pass) begin
          y      = d;
          do_pop = 1'b1;
        end
      end
      LDCT: do_ld = 1'b1;
      LOOP: begin
        if (pass) do_pop = 1'b1;
        else      y      = f;
      end
      CONT: y = upc;
      TWB: begin
        if (pass) begin
          do_pop = 1'b1;
        end else if (!cnt_zero) begin
          y      = f;
          do_dec = 1'b1;
        end else begin
          y      = d;
          do_pop = 1'b1;
        end
      end
      default: y = upc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upc <= '0;
      cnt <= '0;
      sp  <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      upc <= y + AW'(ci);

      // An external load wins over any decrement in the same cycle.
      if (!rld_n || do_ld)
        cnt <= d;
      else if (do_dec)
        cnt <= cnt - R_ONE;

      // Clear beats push; a push into a full stack overwrites the top entry.
      if (do_clr) begin
        sp <= '0;
      end else if (do_push) begin
        if (sp == SP_MAX) begin
          stack[SP_MAX - SP_ONE] <= upc;
        end else begin
          stack[sp] <= upc;
          sp        <= sp + SP_ONE;
        end
      end else if (do_pop && (sp != '0)) begin
        sp <= sp - SP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_microseq.sv
// Directed testbench for microseq: hand-computed next-address sequences
// across all instruction groups, stack overflow/underflow and reset.
module tb_microseq;

  localparam int AW = 12;

  localparam logic [3:0] JZ = 4'd0, CJS = 4'd1, JMAP = 4'd2, CJP = 4'd3,
                         PUSH = 4'd4, JSRP = 4'd5, CJV = 4'd6, JRP = 4'd7,
                         RFCT = 4'd8, RPCT = 4'd9, CRTN = 4'd10, CJPP = 4'd11,
                         LDCT = 4'd12, LOOP = 4'd13, CONT = 4'd14, TWB = 4'd15;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    inst;
  logic          cc_n;
  logic          ccen_n;
  logic [AW-1:0] d;
  logic          rld_n;
  logic          ci;
  logic [AW-1:0] y;
  logic          full_n;
  logic          pl_n;
  logic          map_n;
  logic          vect_n;

  int checks = 0;
  int errors = 0;

  microseq #(.AW(AW), .DEPTH(5)) dut (
    .clk(clk), .reset(reset), .inst(inst), .cc_n(cc_n), .ccen_n(ccen_n),
    .d(d), .rld_n(rld_n), .ci(ci), .y(y), .full_n(full_n),
    .pl_n(pl_n), .map_n(map_n), .vect_n(vect_n)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: apply one instruction with condition mode c (0 pass-forced, 1 pass, 2 fail),
  // check y before the edge, then advance one clock.
  task automatic step(input logic [3:0] i, input int c, input logic [AW-1:0] dv,
                      input logic [AW-1:0] exp_y, input string tag);
    inst   = i;
    d      = dv;
    ccen_n = (c == 0);
    cc_n   = (c == 2);
    #1;
    chk(tag, y, exp_y);
    tick();
  endtask

  initial begin
    reset = 1'b1; inst = CONT; cc_n = 1'b1; ccen_n = 1'b1;
    d = '0; rld_n = 1'b1; ci = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_full_n", AW'(full_n), AW'(1));

    // CONT counts up from zero
    inst = CONT; #1;
    chk("cont_pl_n", AW'(pl_n), AW'(0));
    chk("cont_map_n", AW'(map_n), AW'(1));
    chk("cont_vect_n", AW'(vect_n), AW'(1));
    step(CONT, 0, 12'h000, 12'h000, "cont0");
    step(CONT, 0, 12'h000, 12'h001, "cont1");
    step(CONT, 0, 12'h000, 12'h002, "cont2");
    step(CONT, 0, 12'h000, 12'h003, "cont3");
    chk("cont_full_n", AW'(full_n), AW'(1));

    // CJS / CRTN round trip
    step(CJP,  0, 12'h00F, 12'h00F, "cjp_to_0f");
    step(CJS,  1, 12'h200, 12'h200, "cjs_pass");
    step(CONT, 0, 12'h000, 12'h201, "sub_cont0");
    step(CONT, 0, 12'h000, 12'h202, "sub_cont1");
    step(CRTN, 1, 12'h000, 12'h010, "crtn_ret");
    step(CRTN, 1, 12'h000, 12'h000, "crtn_empty");
    step(CJS,  2, 12'h3FF, 12'h001, "cjs_fail");
    step(CRTN, 1, 12'h000, 12'h000, "crtn_no_push");

    // LDCT / RPCT
    step(LDCT, 0, 12'h003, 12'h001, "ldct3");
    step(RPCT, 0, 12'h050, 12'h050, "rpct_r3");
    step(RPCT, 0, 12'h050, 12'h050, "rpct_r2");
    step(RPCT, 0, 12'h050, 12'h050, "rpct_r1");
    step(RPCT, 0, 12'h050, 12'h051, "rpct_r0");

    // Stack overflow and LIFO returns
    step(CJS, 1, 12'h100, 12'h100, "ovf_cjs1");
    chk("ovf_full1", AW'(full_n), AW'(1));
    step(CJS, 1, 12'h110, 12'h110, "ovf_cjs2");
    step(CJS, 1, 12'h120, 12'h120, "ovf_cjs3");
    step(CJS, 1, 12'h130, 12'h130, "ovf_cjs4");
    chk("ovf_full4", AW'(full_n), AW'(1));
    step(CJS, 1, 12'h140, 12'h140, "ovf_cjs5");
    chk("ovf_full5", AW'(full_n), AW'(0));
    step(CJS, 1, 12'h150, 12'h150, "ovf_cjs6");
    chk("ovf_full6", AW'(full_n), AW'(0));
    step(CRTN, 1, 12'h000, 12'h141, "ovf_ret1");
    chk("ovf_full_after_pop", AW'(full_n), AW'(1));
    step(CRTN, 1, 12'h000, 12'h121, "ovf_ret2");
    step(CRTN, 1, 12'h000, 12'h111, "ovf_ret3");
    step(CRTN, 1, 12'h000, 12'h101, "ovf_ret4");
    step(CRTN, 1, 12'h000, 12'h052, "ovf_ret5");
    step(CRTN, 1, 12'h000, 12'h000, "ovf_ret_empty");
    chk("ovf_full_empty", AW'(full_n), AW'(1));

    // TWB
    step(CJP,  0, 12'h0FF, 12'h0FF, "twb_setup");
    step(PUSH, 1, 12'h001, 12'h100, "twb_push");
    step(TWB,  2, 12'h333, 12'h100, "twb_fail_r1");
    step(TWB,  2, 12'h333, 12'h333, "twb_fail_r0");
    step(PUSH, 1, 12'h005, 12'h334, "twb_push2");
    step(TWB,  1, 12'h333, 12'h335, "twb_pass");
    step(CRTN, 1, 12'h000, 12'h000, "twb_empty");
    step(RPCT, 0, 12'h077, 12'h077, "twb_r_kept");

    // Source enables
    inst = JMAP; d = 12'h2AB; #1;
    chk("jmap_map_n", AW'(map_n), AW'(0));
    chk("jmap_pl_n", AW'(pl_n), AW'(1));
    chk("jmap_vect_n", AW'(vect_n), AW'(1));
    step(JMAP, 2, 12'h2AB, 12'h2AB, "jmap_y");
    inst = CJV; #1;
    chk("cjv_vect_n", AW'(vect_n), AW'(0));
    chk("cjv_pl_n", AW'(pl_n), AW'(1));
    chk("cjv_map_n", AW'(map_n), AW'(1));
    step(CJV, 2, 12'h123, 12'h2AC, "cjv_fail");
    step(CJV, 1, 12'h0A0, 12'h0A0, "cjv_pass");

    // JZ clears a partly filled stack
    step(CJS,  1, 12'h010, 12'h010, "jz_cjs1");
    step(CJS,  1, 12'h020, 12'h020, "jz_cjs2");
    step(CJS,  1, 12'h030, 12'h030, "jz_cjs3");
    step(JZ,   1, 12'h555, 12'h000, "jz_y");
    step(CRTN, 1, 12'h000, 12'h000, "jz_cleared");

    // RFCT with a concurrent external counter load
    step(LDCT, 0, 12'h002, 12'h001, "rfct_ldct2");
    step(PUSH, 2, 12'h999, 12'h002, "rfct_push");
    rld_n = 1'b0;
    step(RFCT, 0, 12'h004, 12'h002, "rfct_rld");
    rld_n = 1'b1;
    step(RFCT, 0, 12'h000, 12'h002, "rfct_r4");
    step(RFCT, 0, 12'h000, 12'h002, "rfct_r3");
    step(RFCT, 0, 12'h000, 12'h002, "rfct_r2");
    step(RFCT, 0, 12'h000, 12'h002, "rfct_r1");
    step(RFCT, 0, 12'h000, 12'h003, "rfct_r0");
    step(CRTN, 1, 12'h000, 12'h000, "rfct_popped");

    // LOOP, JRP, JSRP
    step(CJS,  1, 12'h040, 12'h040, "loop_cjs");
    step(LOOP, 2, 12'h000, 12'h001, "loop_fail");
    step(LOOP, 1, 12'h000, 12'h002, "loop_pass");
    step(CRTN, 1, 12'h000, 12'h000, "loop_popped");
    step(LDCT, 0, 12'h0AA, 12'h001, "jrp_ldct");
    step(JRP,  2, 12'h555, 12'h0AA, "jrp_fail");
    step(JRP,  1, 12'h555, 12'h555, "jrp_pass");
    step(JSRP, 2, 12'h777, 12'h0AA, "jsrp_fail");
    step(CRTN, 1, 12'h000, 12'h556, "jsrp_ret");
    step(CJPP, 2, 12'h600, 12'h557, "cjpp_fail");

    // Reset mid-subroutine discards stack and counter, overriding the instruction
    step(CJS, 1, 12'h300, 12'h300, "rst_cjs");
    reset = 1'b1;
    inst = CJS; cc_n = 1'b0; ccen_n = 1'b0; d = 12'h444;
    tick();
    reset = 1'b0;
    chk("rst_full_n", AW'(full_n), AW'(1));
    step(RPCT, 0, 12'h055, 12'h000, "rst_r_zero");
    step(CRTN, 1, 12'h000, 12'h000, "rst_stack_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
